// File: rtl/spi_reg_ctrl.sv
// SPI-attached register bank controller.
//
// Sits behind a byte-level SPI slave. The first byte of each chip-select
// window is a command (bit7 R/nW, bit6 reserved -> ignore transaction,
// bits3:0 start address). Following bytes are written into, or read out of,
// a 16 x 8 register bank. The user side can read the bank combinationally.
//
// Build option: define SPI_REG_CTRL_AUTOINC_EN to advance the register
// pointer (modulo 16) after every data byte. Without it, the pointer stays
// on the command address for the whole transaction.
module spi_reg_ctrl #(
  parameter logic [7:0] ID_BYTE     = 8'hA5,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CS_i,
  input  logic       Done_i,
  input  logic [7:0] DataReceived_i,
  output logic [7:0] DataToSend_o,
  output logic       WrStrobe_o,
  output logic [3:0] WrAddr_o,
  output logic [7:0] WrData_o,
  input  logic [3:0] RdAddr_i,
  output logic [7:0] RdData_o
);

  localparam int unsigned NumRegs = 16;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCmd    = 3'd1;
  localparam logic [2:0] StWrite  = 3'd2;
  localparam logic [2:0] StRead   = 3'd3;
  localparam logic [2:0] StIgnore = 3'd4;

  // Shifted out for the remainder of an ignored transaction.
  localparam logic [7:0] IgnoreByte = 8'hFF;

  logic [2:0] state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] dts_q, dts_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] bank_q [NumRegs];
  logic [7:0] bank_d [NumRegs];

  // Bank write request from the FSM.
  logic       bank_we;
  logic [3:0] bank_waddr;
  logic [7:0] bank_wdata;

  // Command byte fields.
  logic [3:0] cmd_addr;
  logic       cmd_read;
  logic       cmd_rsvd;

  assign cmd_addr = DataReceived_i[3:0];
  assign cmd_read = DataReceived_i[7];
  assign cmd_rsvd = DataReceived_i[6];

  // Pointer step after each transferred register; wraps 15 -> 0.
  function automatic logic [3:0] next_ptr(input logic [3:0] p);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    return p + 4'd1;
`else
    return p;
`endif
  endfunction

  // Transaction FSM: decodes the command byte and services data bytes.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dts_d       = dts_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_we     = 1'b0;
    bank_waddr  = ptr_q;
    bank_wdata  = DataReceived_i;

    case (state_q)
      StIdle: begin
        // Done_i is deliberately ignored here; only chip select starts a frame.
        if (!CS_i) begin
          state_d = StCmd;
          dts_d   = ID_BYTE;
        end
      end

      StCmd: begin
        if (Done_i) begin
          ptr_d = cmd_addr;
          if (cmd_rsvd) begin
            state_d = StIgnore;
            dts_d   = IgnoreByte;
          end else if (cmd_read) begin
            // First read byte must be ready for the very next SPI byte.
            state_d = StRead;
            dts_d   = bank_q[cmd_addr];
            ptr_d   = next_ptr(cmd_addr);
          end else begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        if (Done_i) begin
          bank_we     = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = ptr_q;
          wr_data_d   = DataReceived_i;
          ptr_d       = next_ptr(ptr_q);
        end
      end

      StRead: begin
        if (Done_i) begin
          dts_d = bank_q[ptr_q];
          ptr_d = next_ptr(ptr_q);
        end
      end

      StIgnore: begin
        // Hold 0xFF on MISO and drop everything until chip select rises.
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Deselect ends the frame after any byte completing in this same cycle
    // has been handled above; a partially shifted byte is simply lost.
    if ((state_q != StIdle) && CS_i) begin
      state_d = StIdle;
    end
  end

  // Next-state of the register bank.
  always_comb begin
    bank_d = bank_q;
    if (bank_we) begin
      bank_d[bank_waddr] = bank_wdata;
    end
  end

  // Control and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      ptr_q       <= 4'h0;
      dts_q       <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'h0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dts_q       <= dts_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register bank storage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        bank_q[i] <= RESET_VALUE;
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  assign DataToSend_o = dts_q;
  assign WrStrobe_o   = wr_strobe_q;
  assign WrAddr_o     = wr_addr_q;
  assign WrData_o     = wr_data_q;
  assign RdData_o     = bank_q[RdAddr_i];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios with literal expectations, then
// randomized chip-select frames checked every cycle against a byte-counting
// transaction model. Honours SPI_REG_CTRL_AUTOINC_EN like the design.
module tb_spi_reg_ctrl;

  localparam logic [7:0] IdByte     = 8'hA5;
  localparam logic [7:0] ResetValue = 8'h00;
`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b1;
  logic       done = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] dts;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  spi_reg_ctrl #(
    .ID_BYTE     (IdByte),
    .RESET_VALUE (ResetValue)
  ) dut (
    .Clock          (clk),
    .Reset          (rst),
    .CS_i           (cs),
    .Done_i         (done),
    .DataReceived_i (din),
    .DataToSend_o   (dts),
    .WrStrobe_o     (wr_strobe),
    .WrAddr_o       (wr_addr),
    .WrData_o       (wr_data),
    .RdAddr_i       (rd_addr),
    .RdData_o       (rd_data)
  );

  // Transaction model: a frame is "bytes received since CS fell"; byte 0 is
  // the command, byte n addresses register (cmd_addr + n or n-1) mod 16.
  logic [7:0] m_bank [16];
  bit         m_in_txn = 1'b0;
  int         m_nb = 0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_dts = 8'h00;
  bit         m_strobe = 1'b0;
  logic [3:0] m_waddr = 4'h0;
  logic [7:0] m_wdata = 8'h00;

  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  bit         rnd_rd = 1'b0;
  logic [3:0] strobe_log [$];

  function automatic logic [3:0] slot(input logic [3:0] base, input int off);
    int s;
    s = int'(base) + (AutoInc ? off : 0);
    return s[3:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic model_step();
    logic [3:0] idx;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_bank[i] = ResetValue;
      m_in_txn = 1'b0;
      m_nb     = 0;
      m_dts    = 8'h00;
      m_strobe = 1'b0;
      m_waddr  = 4'h0;
      m_wdata  = 8'h00;
      return;
    end
    m_strobe = 1'b0;
    if (!m_in_txn) begin
      if (!cs) begin
        m_in_txn = 1'b1;
        m_nb     = 0;
        m_dts    = IdByte;
      end
    end else begin
      if (done) begin
        if (m_nb == 0) begin
          m_cmd = din;
          if (din[6]) m_dts = 8'hFF;
          else if (din[7]) m_dts = m_bank[din[3:0]];
        end else if (!m_cmd[6]) begin
          if (m_cmd[7]) begin
            m_dts = m_bank[slot(m_cmd[3:0], m_nb)];
          end else begin
            idx         = slot(m_cmd[3:0], m_nb - 1);
            m_bank[idx] = din;
            m_strobe    = 1'b1;
            m_waddr     = idx;
            m_wdata     = din;
          end
        end
        m_nb++;
      end
      if (cs) m_in_txn = 1'b0;
    end
  endtask

  // One clock: present inputs, let the edge happen, update model.
  task automatic cycle(input bit c, input bit d, input logic [7:0] b);
    cs   = c;
    done = d;
    din  = b;
    if (rnd_rd) rd_addr = 4'($urandom);
    @(posedge clk);
    model_step();
    #1;
    done = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, b);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("miso", dts, m_dts);
      check("strobe", {7'd0, wr_strobe}, {7'd0, m_strobe});
      check("wr_addr", {4'h0, wr_addr}, {4'h0, m_waddr});
      check("wr_data", wr_data, m_wdata);
      check("rd_data", rd_data, m_bank[rd_addr]);
      if (wr_strobe) strobe_log.push_back(wr_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_miso", dts, 8'h00);
    check("rst_strobe", {7'd0, wr_strobe}, 8'h00);
    rd_check("rst_bank5", 4'd5, ResetValue);

    // Write 0x11, 0x22 from address 3
    strobe_log.delete();
    cycle(1'b0, 1'b0, 8'h00);
    check("id_byte", dts, 8'hA5);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("wr_pulses", 8'(strobe_log.size()), 8'd2);
    if (strobe_log.size() == 2) begin
      check("wr_addr0", {4'h0, strobe_log[0]}, 8'h03);
      check("wr_addr1", {4'h0, strobe_log[1]}, AutoInc ? 8'h04 : 8'h03);
    end
    rd_check("bank3", 4'd3, AutoInc ? 8'h11 : 8'h22);
    rd_check("bank4", 4'd4, AutoInc ? 8'h22 : ResetValue);

    // Read back from address 3
    cycle(1'b0, 1'b0, 8'h00);
    check("rd_id", dts, 8'hA5);
    send(8'h83);
    check("rd_byte0", dts, AutoInc ? 8'h11 : 8'h22);
    send(8'h00);
    check("rd_byte1", dts, 8'h22);
    cycle(1'b1, 1'b0, 8'h00);

    // Reserved bit set: frame ignored
    strobe_log.delete();
    cycle(1'b0, 1'b0, 8'h00);
    send(8'h45);
    check("ign_ff", dts, 8'hFF);
    send(8'h77);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("ign_pulses", 8'(strobe_log.size()), 8'd0);
    rd_check("ign_bank5", 4'd5, ResetValue);

    // Wrap from address 15
    cycle(1'b0, 1'b0, 8'h00);
    send(8'h0F);
    send(8'hAA);
    send(8'hBB);
    cycle(1'b1, 1'b0, 8'h00);
    rd_check("bank15", 4'd15, AutoInc ? 8'hAA : 8'hBB);
    rd_check("bank0", 4'd0, AutoInc ? 8'hBB : ResetValue);

    // CS rises with the data byte's Done
    cycle(1'b0, 1'b0, 8'h00);
    send(8'h05);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h5A);
    check("cs_done_strobe", {7'd0, wr_strobe}, 8'h01);
    check("cs_done_addr", {4'h0, wr_addr}, 8'h05);
    check("cs_done_data", wr_data, 8'h5A);
    cycle(1'b1, 1'b1, 8'h66);
    check("idle_done_strobe", {7'd0, wr_strobe}, 8'h00);
    rd_check("bank5_5a", 4'd5, 8'h5A);

    // Reset between command and data byte
    cycle(1'b0, 1'b0, 8'h00);
    send(8'h02);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 8'h99);
    rst = 1'b0;
    check("midrst_miso", dts, 8'h00);
    check("midrst_strobe", {7'd0, wr_strobe}, 8'h00);
    rd_check("midrst_bank2", 4'd2, ResetValue);
    rd_check("midrst_bank3", 4'd3, ResetValue);
    cycle(1'b1, 1'b0, 8'h00);

    // Randomized frames
    rnd_rd = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int nb;
      nb = $urandom_range(1, 6);
      cycle(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
      for (int k = 0; k < nb; k++) begin
        logic [7:0] b;
        int         gap;
        bit         last_cs;
        b = 8'($urandom);
        if (k == 0) b[6] = ($urandom_range(0, 4) == 0);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 8'($urandom));
        last_cs = (k == nb - 1) && ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 99) == 0) begin
          rst = 1'b1;
          cycle(1'b0, 1'b1, b);
          rst = 1'b0;
        end else begin
          cycle(last_cs, 1'b1, b);
        end
      end
      repeat ($urandom_range(1, 3)) cycle(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
